// File: rtl/comp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // One-hot result encoding, ordered {gt, eq, lt}
    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int unsigned num_digits(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned ndig);
        return (ndig <= 1) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/comp_digit.sv
// Combinational DIGIT-bit unsigned comparator; parametrised form of the 1-bit gt/lt cell.
module comp_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             dgt,
    output logic             dlt
);

    always_comb begin
        dgt = (x > y);
        dlt = (x < y);
    end

endmodule

// File: rtl/comp_serial.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per clock, optional early exit.
module comp_serial
    import comp_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DIGIT      = 4,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int unsigned NDIG = num_digits(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_width(NDIG);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state, state_nx;
    logic [WIDTH-1:0] sa, sb;
    logic [CW-1:0]    cnt;
    logic             decided, dec_gt;
    logic             dgt, dlt;
    logic             accept, first_diff, finish;
    logic [2:0]       res;

    assign {gt, eq, lt} = res;

    comp_digit #(.DIGIT(DIGIT)) u_digit (
        .x   (sa[WIDTH-1 -: DIGIT]),
        .y   (sb[WIDTH-1 -: DIGIT]),
        .dgt (dgt),
        .dlt (dlt)
    );

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        first_diff = !decided && (dgt || dlt);
        finish     = (EARLY_EXIT && first_diff) || (cnt == '0);
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (finish) state_nx = DONE;
            end
            DONE: begin
                accept   = start;
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            res     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // Flipping the sign bit maps two's complement onto offset binary
                sa      <= signed_mode ? (a ^ MSB) : a;
                sb      <= signed_mode ? (b ^ MSB) : b;
                cnt     <= CW'(NDIG - 1);
                decided <= 1'b0;
            end else if (state == RUN) begin
                sa  <= sa << DIGIT;
                sb  <= sb << DIGIT;
                cnt <= cnt - 1'b1;
                if (first_diff) begin
                    decided <= 1'b1;
                    dec_gt  <= dgt;
                end
                if (finish) begin
                    if (decided)  res <= dec_gt ? RES_GT : RES_LT;
                    else if (dgt) res <= RES_GT;
                    else if (dlt) res <= RES_LT;
                    else          res <= RES_EQ;
                end
            end
        end
    end

endmodule
